// File: rtl/dac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_ctrl_pkg
// Purpose  : Shared types and constants for the DAC sample scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dac_ctrl_pkg;

    localparam int          CNT_W    = 16;
    localparam logic [15:0] MIDSCALE = 16'h8000;

    typedef logic [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Purpose  : Synchronous show-ahead FIFO of audio samples. rd_data always
//            presents the head entry; rd_en consumes it.
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo
    import dac_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  sample_t                wr_data,
    input  logic                   rd_en,
    output sample_t                rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    sample_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic               w_do_wr;
    logic               w_do_rd;

    // Guard both ports so a careless caller cannot corrupt the occupancy.
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;

    assign full    = (r_level == LVL_W'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_scheduler
// Purpose  : Paces the SPI DAC driver at a fixed sample rate. Buffers
//            upstream samples, issues one start pulse per sample tick and
//            follows the driver chip-select until the transfer completes.
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_scheduler
    import dac_ctrl_pkg::*;
#(
    parameter int DIV           = 521,
    parameter int DEPTH         = 8,
    parameter int MAX_XFER      = 1024,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic                   clk_25mhz,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   clear_status,
    input  logic [15:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [15:0]            dac_data_out,
    output logic                   dac_data_ready,
    input  logic                   dac_active_in,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            underrun_count,
    output logic [15:0]            missed_ticks,
    output logic                   timeout_err
);

    localparam int TICK_W = $clog2(DIV);
    localparam int XFER_W = $clog2(MAX_XFER + 1);

    logic [TICK_W-1:0]  r_tick_cnt;
    sched_state_t       r_state;
    sample_t            r_data;
    sample_t            r_last;
    logic [XFER_W-1:0]  r_xfer_cnt;
    logic [CNT_W-1:0]   r_underrun_cnt;
    logic [CNT_W-1:0]   r_missed_cnt;
    logic               r_timeout;
    logic               r_live;

    logic               w_tick;
    logic               w_full;
    logic               w_empty;
    sample_t            w_rd_data;
    logic               w_pop;
    logic               w_underrun;
    logic               w_missed;
    logic               w_xfer_limit;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_25mhz),
        .rst_n   (reset_n),
        .wr_en   (s_valid && s_ready),
        .wr_data (s_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    // s_ready stays low while in reset and rises on the first clock after.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    assign s_ready = r_live && !w_full;

    // ------------------------------------------------------------------
    // Sample-rate tick: count 0..DIV-1 while enabled, parked at 0 otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (!enable || (r_tick_cnt == TICK_W'(DIV - 1))) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = enable && (r_tick_cnt == TICK_W'(DIV - 1));

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_pop      = (r_state == IDLE) && w_tick && !w_empty;
    assign w_underrun = (r_state == IDLE) && w_tick &&  w_empty;
    assign w_missed   = (r_state != IDLE) && w_tick;

    // r_xfer_cnt holds cycles elapsed since LOAD; the limit fires in the
    // cycle whose successor would be the MAX_XFER-th.
    assign w_xfer_limit = (r_xfer_cnt == XFER_W'(MAX_XFER - 1));

    // A completing handshake in the limit cycle wins over the timeout.
    assign w_timeout = w_xfer_limit &&
                       (((r_state == WAIT_START) &&  dac_active_in) ||
                        ((r_state == WAIT_DONE)  && !dac_active_in));

    assign dac_data_ready = (r_state == LOAD);
    assign dac_data_out   = r_data;

    // Transfer sequencer; output data only changes on an IDLE tick, which
    // keeps it stable from LOAD until the next accepted tick.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_last     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state <= LOAD;
                        if (!w_empty) begin
                            r_data <= w_rd_data;
                            r_last <= w_rd_data;
                        end else begin
                            r_data <= (UNDERRUN_HOLD != 0) ? r_last : MIDSCALE;
                        end
                    end
                end
                LOAD: begin
                    r_state    <= WAIT_START;
                    r_xfer_cnt <= XFER_W'(1);
                end
                WAIT_START: begin
                    r_xfer_cnt <= r_xfer_cnt + XFER_W'(1);
                    if (!dac_active_in)    r_state <= WAIT_DONE;
                    else if (w_xfer_limit) r_state <= IDLE;
                end
                WAIT_DONE: begin
                    r_xfer_cnt <= r_xfer_cnt + XFER_W'(1);
                    if (dac_active_in)     r_state <= IDLE;
                    else if (w_xfer_limit) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Status counters and sticky flag; clear_status overrides any increment.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun_cnt <= '0;
            r_missed_cnt   <= '0;
            r_timeout      <= 1'b0;
        end else if (clear_status) begin
            r_underrun_cnt <= '0;
            r_missed_cnt   <= '0;
            r_timeout      <= 1'b0;
        end else begin
            if (w_underrun) r_underrun_cnt <= sat_inc(r_underrun_cnt);
            if (w_missed)   r_missed_cnt   <= sat_inc(r_missed_cnt);
            if (w_timeout)  r_timeout      <= 1'b1;
        end
    end

    assign underrun_count = r_underrun_cnt;
    assign missed_ticks   = r_missed_cnt;
    assign timeout_err    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dac_sample_scheduler
// Purpose  : Self-checking bench for dac_sample_scheduler. Two instances run
//            in lockstep, differing only in the underrun fallback policy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_sample_scheduler;

    localparam int DIV      = 100;
    localparam int DEPTH    = 8;
    localparam int MAX_XFER = 200;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear_status;
    logic [15:0] s_data;
    logic        s_valid;
    logic        dac_active = 1'b1;

    logic        s_ready0, s_ready1, rdy0, rdy1, to0, to1;
    logic [15:0] data0, data1, und0, und1, mis0, mis1;
    logic [3:0]  lvl0, lvl1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_sample_scheduler #(
        .DIV(DIV), .DEPTH(DEPTH), .MAX_XFER(MAX_XFER), .UNDERRUN_HOLD(1)
    ) u_dut_hold (
        .clk_25mhz(clk), .reset_n(reset_n), .enable(enable),
        .clear_status(clear_status), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .dac_data_out(data0), .dac_data_ready(rdy0),
        .dac_active_in(dac_active), .fifo_level(lvl0),
        .underrun_count(und0), .missed_ticks(mis0), .timeout_err(to0)
    );

    dac_sample_scheduler #(
        .DIV(DIV), .DEPTH(DEPTH), .MAX_XFER(MAX_XFER), .UNDERRUN_HOLD(0)
    ) u_dut_mid (
        .clk_25mhz(clk), .reset_n(reset_n), .enable(enable),
        .clear_status(clear_status), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .dac_data_out(data1), .dac_data_ready(rdy1),
        .dac_active_in(dac_active), .fifo_level(lvl1),
        .underrun_count(und1), .missed_ticks(mis1), .timeout_err(to1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver model: CS low 3 cycles after the pulse, held low drv_hold cycles.
    int drv_hold  = 68;
    bit drv_never = 1'b0;
    int drv_dly   = 0;
    int drv_left  = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            drv_dly    = 0;
            drv_left   = 0;
            dac_active = 1'b1;
        end else if (drv_dly > 0) begin
            drv_dly--;
            if (drv_dly == 0) begin
                dac_active = 1'b0;
                drv_left   = drv_hold;
            end
        end else if (drv_left > 0) begin
            drv_left--;
            if (drv_left == 0) dac_active = 1'b1;
        end else if (rdy0 && !drv_never) begin
            drv_dly = 3;
        end
    end

    // Transaction-level reference model for the randomized phase.
    typedef struct {
        logic [15:0] d;
        int          c;
    } push_t;

    push_t       m_q[$];
    bit          rand_on  = 1'b0;
    bit          m_pend   = 1'b0;
    int          m_level  = 0;
    int          m_under  = 0;
    int          m_prev   = 0;
    int          m_pulses = 0;
    logic [15:0] m_last   = 16'h0000;

    always @(negedge clk) begin
        int          k;
        logic [15:0] e0;
        logic [15:0] e1;
        push_t       pe;
        if (rand_on) begin
            k = cyc;
            if (m_pend) begin
                m_level++;
                m_pend = 1'b0;
            end
            if (rdy0) begin
                // The tick was the previous cycle; only words pushed before it count.
                if (m_q.size() > 0 && m_q[0].c <= k - 2) begin
                    pe     = m_q.pop_front();
                    e0     = pe.d;
                    e1     = pe.d;
                    m_last = pe.d;
                    m_level--;
                end else begin
                    e0 = m_last;
                    e1 = 16'h8000;
                    m_under++;
                end
                chk("rand_data_hold", data0, e0);
                chk("rand_data_mid", data1, e1);
                chk("rand_interval", k - m_prev, DIV);
                m_prev = k;
                m_pulses++;
            end
            chk("rand_level", lvl0, m_level);
            chk("rand_ready", s_ready0, m_level < DEPTH);
            if (s_valid && m_level < DEPTH) begin
                pe.d = s_data;
                pe.c = k;
                m_q.push_back(pe);
                m_pend = 1'b1;
            end
        end
    end

    task automatic wait_pulse(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rdy0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("pulse_timeout", 0, 1);
    endtask

    task automatic push_word(input logic [15:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic        exp_ready;
        logic [3:0]  exp_level;
    } push_vec_t;

    push_vec_t vecs [9];

    initial begin
        int p_a, p_b, tat, nchg, npul;
        logic [15:0] hold0, hold1;

        for (int i = 0; i < 9; i++) begin
            vecs[i].d         = 16'(i + 1);
            vecs[i].exp_ready = (i < DEPTH);
            vecs[i].exp_level = (i < DEPTH) ? 4'(i) : 4'(DEPTH);
        end

        reset_n = 1'b0; enable = 1'b0; clear_status = 1'b0;
        s_valid = 1'b0; s_data = 16'h0000;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_data", data0, 0);
        chk("rst_ready_pulse", rdy0, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_underrun", und0, 0);
        chk("rst_missed", mis0, 0);
        chk("rst_timeout", to0, 0);
        chk("rst_s_ready", s_ready0, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("s_ready_after_release", s_ready0, 1);

        // ---- normal stream ----
        push_word(16'hABCD);
        push_word(16'h1234);
        chk("level_two", lvl0, 2);
        enable = 1'b1;
        wait_pulse(200, p_a);
        chk("stream_first", data0, 16'hABCD);
        chk("stream_first_mid", data1, 16'hABCD);
        chk("pulse_lockstep", rdy1, 1);
        wait_pulse(200, p_b);
        chk("stream_second", data0, 16'h1234);
        chk("stream_interval", p_b - p_a, DIV);
        chk("stream_missed", mis0, 0);
        chk("stream_timeout", to0, 0);

        // ---- underrun ----
        p_a = p_b;
        wait_pulse(200, p_b);
        chk("underrun_hold", data0, 16'h1234);
        chk("underrun_mid", data1, 16'h8000);
        chk("underrun_cnt", und0, 1);
        chk("underrun_cnt_mid", und1, 1);
        chk("underrun_interval", p_b - p_a, DIV);

        // ---- full FIFO, table driven ----
        repeat (80) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("fill_ready", s_ready0, vecs[i].exp_ready);
            chk("fill_level", lvl0, vecs[i].exp_level);
            s_valid = 1'b1;
            s_data  = vecs[i].d;
        end
        @(negedge clk);
        chk("full_level", lvl0, DEPTH);
        chk("full_ready", s_ready0, 0);
        enable = 1'b1;
        wait_pulse(200, p_a);
        chk("drain_word1", data0, 1);
        chk("drain_level_after_pop", lvl0, DEPTH - 1);
        chk("drain_ready_after_pop", s_ready0, 1);
        @(negedge clk);
        chk("held_word_accepted", lvl0, DEPTH);
        s_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            wait_pulse(200, p_b);
            chk("drain_word", data0, k);
            chk("drain_word_mid", data1, k);
            chk("drain_interval", p_b - p_a, DIV);
            p_a = p_b;
        end

        // ---- timeout ----
        repeat (80) @(negedge clk);
        drv_never    = 1'b1;
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("clear_underrun", und0, 0);
        wait_pulse(200, p_a);
        chk("timeout_pulse_data", data0, 9);
        chk("timeout_pulse_mid", data1, 16'h8000);
        tat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (to0) begin
                tat = cyc;
                break;
            end
        end
        chk("timeout_latency", tat - p_a, MAX_XFER);
        chk("timeout_mid", to1, 1);
        wait_pulse(350, p_b);
        chk("pulse_after_timeout", p_b - p_a, 3 * DIV);
        chk("timeout_missed", mis0, 2);
        chk("timeout_underruns", und0, 2);
        chk("timeout_sticky", to0, 1);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        drv_never    = 1'b0;
        drv_hold     = 150;
        chk("clear_timeout", to0, 0);
        chk("clear_missed", mis0, 0);
        chk("clear_underrun2", und0, 0);

        // ---- missed tick with long CS low ----
        wait_pulse(350, p_a);
        chk("long_xfer_data", data0, 9);
        hold0 = data0;
        hold1 = data1;
        clear_status = 1'b1;
        nchg = 0;
        npul = 0;
        for (int i = 1; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (i == 1) clear_status = 1'b0;
            if (data0 !== hold0 || data1 !== hold1) nchg++;
            if (rdy0) npul++;
        end
        chk("data_held_stable", nchg, 0);
        chk("no_pulse_while_busy", npul, 0);
        wait_pulse(5, p_b);
        drv_hold = 68;
        chk("pulse_after_long", p_b - p_a, 2 * DIV);
        chk("missed_one", mis0, 1);
        chk("missed_one_mid", mis1, 1);
        chk("long_no_timeout", to0, 0);

        // ---- reset in WAIT_DONE ----
        push_word(16'h5A5A);
        push_word(16'h1111);
        push_word(16'h2222);
        wait_pulse(200, p_a);
        chk("pre_reset_data", data0, 16'h5A5A);
        repeat (20) @(negedge clk);
        chk("pre_reset_level", lvl0, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_data", data0, 0);
        chk("async_rst_data_mid", data1, 0);
        chk("async_rst_pulse", rdy0, 0);
        chk("async_rst_level", lvl0, 0);
        chk("async_rst_level_mid", lvl1, 0);
        chk("async_rst_missed", mis0, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_pulse(200, p_a);
        chk("post_reset_hold_zero", data0, 16'h0000);
        chk("post_reset_mid", data1, 16'h8000);
        chk("post_reset_underrun", und0, 1);

        // ---- randomized stream against the reference model ----
        m_last   = 16'h0000;
        m_under  = 1;
        m_prev   = p_a;
        m_level  = 0;
        m_pulses = 0;
        @(posedge clk);
        rand_on = 1'b1;
        for (int i = 0; i < 4000 && m_pulses < 30; i++) begin
            #2;
            s_valid = ($urandom_range(0, 89) == 0);
            s_data  = 16'($urandom);
            @(posedge clk);
        end
        rand_on = 1'b0;
        #2;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rand_pulse_count", m_pulses >= 30, 1);
        chk("rand_underruns", und0, m_under);
        chk("rand_underruns_mid", und1, m_under);
        chk("rand_missed", mis0, 0);
        chk("rand_timeout", to0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
Sequences the SPI DAC driver at a fixed audio sample rate. Buffers upstream samples in a small FIFO (valid/ready). On each sample tick it pops one word, or substitutes a fallback on underrun, and pulses the driver's data_ready. It then tracks the driver's chip-select to know when the transfer is done. Sits between the audio source and dac_driver in the 25 MHz domain.

Parameters:
DIV, 521, clk_25mhz cycles per sample tick (25 MHz / 48 kHz); must be >= 4.
DEPTH, 8, FIFO depth; power of 2, >= 2.
MAX_XFER, 1024, cycle limit for one transaction (pulse to CS release) before timeout.
UNDERRUN_HOLD, 1, underrun fallback: 1 = repeat last sample; 0 = send 16'h8000 midscale.

Ports:
clk_25mhz  in  1  system clock
reset_n  in  1  async active-low reset
enable  in  1  tick generator enable
clear_status  in  1  one-cycle pulse; clears sticky flags and counters
s_data  in  16  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  FIFO not full
dac_data_out  out  16  to dac_driver mosi_in
dac_data_ready  out  1  one-cycle start pulse to dac_driver data_ready
dac_active_in  in  1  dac_driver active_out (CS); 0 = transfer in progress
fifo_level  out  $clog2(DEPTH)+1  current occupancy
underrun_count  out  16  saturating count of underruns
missed_ticks  out  16  saturating count of ticks that arrived while not IDLE
timeout_err  out  1  sticky flag; set on transaction timeout

Behaviour:
- Reset (async, reset_n=0): all outputs 0; s_ready becomes 1 after release; FIFO empty; last-sample register 0; state IDLE; tick counter 0.
- Tick counter:
  - enable=1: counts 0..DIV-1 and wraps; tick is asserted in the cycle where the count equals DIV-1.
  - enable=0: counter held at 0, no ticks. An in-flight transaction still completes.
- FIFO:
  - Push when s_valid && s_ready. s_ready = !full, registered-state based.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - Push to a full FIFO is impossible (s_ready=0). Pop from an empty FIFO does not occur; it is treated as underrun.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
  - IDLE, on tick:
    - FIFO non-empty: pop into dac_data_out and the last-sample register.
    - FIFO empty: dac_data_out = last sample (UNDERRUN_HOLD=1) or 16'h8000 (UNDERRUN_HOLD=0); underrun_count += 1, saturating at 16'hFFFF.
    - Either way, go to LOAD.
  - LOAD: dac_data_ready=1 for exactly this cycle. dac_data_out is already stable, one cycle before the pulse. Go to WAIT_START.
  - WAIT_START: wait for dac_active_in==0, then go to WAIT_DONE.
  - WAIT_DONE: wait for dac_active_in==1, then go to IDLE.
  - dac_data_out is held constant from LOAD until the return to IDLE.
- Timeout: a transaction counter starts at LOAD. If it reaches MAX_XFER in WAIT_START or WAIT_DONE: set timeout_err, go to IDLE. The sample is dropped, not retried.
- A tick in any state other than IDLE: missed_ticks += 1 (saturating); no pop, no pulse.
- Ticks are not queued: the next transfer starts only at the next tick after reaching IDLE.
- clear_status has priority over increments in the same cycle: counters go to 0 and timeout_err to 0. FIFO and FSM are unaffected.
- dac_active_in is same-domain; no synchroniser.

Decomposition:
- Package dac_ctrl_pkg holds:
  - sample_t (logic [15:0])
  - sched_state_t enum (IDLE, LOAD, WAIT_START, WAIT_DONE)
  - MIDSCALE = 16'h8000
  - CNT_W = 16
- Sub-module sample_fifo: synchronous FIFO parameterised on DEPTH, with wr_en/rd_en/full/empty/level.

Test Plan:
- Bench setup: DIV=100, DEPTH=8, MAX_XFER=200. Driver model pulls CS low 3 cycles after the data_ready pulse and holds it low 68 cycles.
- Normal stream: push 16'hABCD then 16'h1234, enable=1 -> dac_data_ready pulses 100 cycles apart with dac_data_out=ABCD then 1234; missed_ticks=0; timeout_err=0.
- Underrun hold: after the scenario above, leave the FIFO empty for the next tick -> dac_data_out=1234 and underrun_count=1. Repeat the same stimulus with UNDERRUN_HOLD=0 -> dac_data_out=8000.
- Full FIFO: enable=0, push 9 words 0x0001..0x0009 -> s_ready=0 after the 8th, fifo_level=8, the 9th is held. Set enable=1 -> words 1..9 appear in order, one per tick.
- Timeout: driver model never lowers CS -> timeout_err=1 exactly 200 cycles after LOAD, FSM returns to IDLE, and the next tick issues a new pulse. clear_status -> timeout_err=0.
- Missed tick: driver holds CS low 150 cycles -> missed_ticks=1 per overlapping tick, no second pulse during CS low, and data is held stable.
- Reset mid-transfer: assert reset_n=0 in WAIT_DONE -> dac_data_ready=0, dac_data_out=0 and fifo_level=0 immediately, without waiting for a clock edge. After release, the first tick with an empty FIFO sends 16'h0000 (UNDERRUN_HOLD=1).
